// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and data memory.
// On contention the requester that was not served last gets the memory. Each access lasts LAT cycles and is followed by one ack cycle.
module mem_arbiter #(
  parameter int LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        busy_o
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_DM = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        owner_reg, last_owner_reg;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [31:0] if_data_reg, dm_rdata_reg;
  logic        grant, grant_dm, last_beat;

  always_comb begin
    grant      = (state_reg == IDLE) && (if_req_i || dm_req_i);
    grant_dm   = dm_req_i && (!if_req_i || (last_owner_reg == OWNER_IF));
    last_beat  = (state_reg == ACCESS) && (cnt_reg == 4'd0);
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      owner_reg      <= OWNER_IF;
      last_owner_reg <= OWNER_IF;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      if_data_reg    <= '0;
      dm_rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        cnt_reg        <= CNT_LOAD;
        owner_reg      <= grant_dm;
        last_owner_reg <= grant_dm;
        addr_reg       <= grant_dm ? dm_addr_i : if_addr_i;
        we_reg         <= grant_dm & dm_we_i;
        wdata_reg      <= grant_dm ? dm_wdata_i : 32'd0;
      end else if ((state_reg == ACCESS) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      // Read data is only valid on the final access cycle, so capture exactly there.
      if (last_beat && !we_reg) begin
        if (owner_reg == OWNER_DM) dm_rdata_reg <= mem_rdata_i;
        else                       if_data_reg  <= mem_rdata_i;
      end
    end
  end

  assign mem_en_o    = (state_reg == ACCESS);
  assign mem_we_o    = mem_en_o & we_reg;
  assign mem_addr_o  = mem_en_o ? addr_reg : 32'd0;
  assign mem_wdata_o = mem_en_o ? wdata_reg : 32'd0;
  assign if_ack_o    = (state_reg == RESP) && (owner_reg == OWNER_IF);
  assign dm_ack_o    = (state_reg == RESP) && (owner_reg == OWNER_DM);
  assign if_data_o   = if_data_reg;
  assign dm_rdata_o  = dm_rdata_reg;
  assign busy_o      = (state_reg != IDLE);
  // Gated by reset so every output reads 0 while reset is held.
  assign stall_o     = !rst_i && ((if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios followed by randomized traffic from both requesters.
module tb_mem_arbiter;
  localparam int LAT = 3;
  localparam int PER = LAT + 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_data_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  txn_t        if_q[$];
  txn_t        dm_q[$];
  logic [31:0] phys [64];
  logic [31:0] ref_mem [64];
  int          en_run = 0;
  logic [31:0] dm_last = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] en_v, we_v, ia_v, da_v, st_v;

  function automatic logic [31:0] seed_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  function automatic logic [63:0] span(input int lo, input int len);
    return ((64'd1 << len) - 64'd1) << lo;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: data is presented correctly only in the LAT-th consecutive enabled cycle.
  always_comb mem_rdata_i = (en_run == LAT) ? phys[mem_addr_o[7:2]] : ~phys[mem_addr_o[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) phys[i] = seed_word(i);
    phys[4] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk_i);
      if (mem_en_o && mem_we_o) phys[mem_addr_o[7:2]] = mem_wdata_o;
      en_run = mem_en_o ? en_run + 1 : 0;
    end
  end

  // Monitor: bus contents, stall/busy and scoreboard pops on every ack.
  initial begin
    txn_t t;
    logic ok, prev_ia, prev_da;
    prev_ia = 1'b0;
    prev_da = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("reset_outputs_zero", 64'(|{if_ack_o, if_data_o, dm_ack_o, dm_rdata_o, mem_en_o, mem_we_o,
                                           mem_addr_o, mem_wdata_o, stall_o, busy_o}), 64'd0);
        prev_ia = 1'b0;
        prev_da = 1'b0;
      end else begin
        check("stall", 64'(stall_o), 64'((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o)));
        check("busy", 64'(busy_o), 64'(mem_en_o | if_ack_o | dm_ack_o));
        if (mem_en_o) begin
          ok = 1'b0;
          if (if_q.size() > 0 && !mem_we_o && mem_addr_o == if_q[0].addr && mem_wdata_o == 32'd0) ok = 1'b1;
          if (dm_q.size() > 0 && mem_we_o == dm_q[0].we && mem_addr_o == dm_q[0].addr &&
              mem_wdata_o == dm_q[0].wdata) ok = 1'b1;
          check("bus_matches_pending", 64'(ok), 64'd1);
        end else begin
          check("bus_idle_zero", 64'(|{mem_we_o, mem_addr_o, mem_wdata_o}), 64'd0);
        end
        if (if_ack_o && dm_ack_o) check("dual_ack", 64'd1, 64'd0);
        if (if_ack_o) begin
          check("if_ack_single_cycle", 64'(prev_ia), 64'd0);
          if (if_q.size() == 0) check("if_ack_unexpected", 64'd1, 64'd0);
          else begin
            t = if_q.pop_front();
            check("if_data", 64'(if_data_o), 64'(t.data));
          end
        end
        if (dm_ack_o) begin
          check("dm_ack_single_cycle", 64'(prev_da), 64'd0);
          if (dm_q.size() == 0) check("dm_ack_unexpected", 64'd1, 64'd0);
          else begin
            t = dm_q.pop_front();
            if (!t.we) dm_last = t.data;
            check(t.we ? "dm_rdata_after_write" : "dm_rdata", 64'(dm_rdata_o), 64'(dm_last));
          end
        end
        prev_ia = if_ack_o;
        prev_da = dm_ack_o;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] addr, input int cnt);
    txn_t t;
    t.we = 1'b0; t.addr = addr; t.wdata = 32'd0; t.data = ref_mem[addr[7:2]];
    for (int k = 0; k < cnt; k++) if_q.push_back(t);
    if_addr_i = addr;
    if_req_i  = 1'b1;
  endtask

  task automatic issue_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int cnt);
    txn_t t;
    if (we) ref_mem[addr[7:2]] = wdata;
    t.we = we; t.addr = addr; t.wdata = wdata; t.data = we ? 32'd0 : ref_mem[addr[7:2]];
    for (int k = 0; k < cnt; k++) dm_q.push_back(t);
    dm_we_i    = we;
    dm_addr_i  = addr;
    dm_wdata_i = wdata;
    dm_req_i   = 1'b1;
  endtask

  task automatic do_reset();
    rst_i    = 1'b1;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    if_q.delete();
    dm_q.delete();
    dm_last  = 32'd0;
    tick();
    rst_i    = 1'b0;
  endtask

  // Records cycle-indexed activity; each requester drops its request after the given number of acks.
  task automatic run_cycles(input int n, input int if_drop, input int dm_drop);
    int   ia_cnt, da_cnt;
    logic ia, da;
    ia_cnt = 0; da_cnt = 0;
    en_v = '0; we_v = '0; ia_v = '0; da_v = '0; st_v = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      en_v[c] = mem_en_o; we_v[c] = mem_we_o; ia_v[c] = if_ack_o; da_v[c] = dm_ack_o; st_v[c] = stall_o;
      ia = if_ack_o;
      da = dm_ack_o;
      if (ia) ia_cnt++;
      if (da) da_cnt++;
      tick();
      if (ia && ia_cnt == if_drop) if_req_i = 1'b0;
      if (da && da_cnt == dm_drop) dm_req_i = 1'b0;
    end
  endtask

  task automatic if_driver(input int n);
    int idx;
    logic got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) tick();
      idx = 32 + int'($urandom_range(0, 31));
      issue_if(32'(idx) << 2, 1);
      got = 1'b0;
      for (int w = 0; w < 2 * PER && !got; w++) begin
        @(negedge clk_i);
        if (if_ack_o) got = 1'b1;
      end
      check("if_wait_bound", 64'(got), 64'd1);
      tick();
      if_req_i = 1'b0;
    end
  endtask

  task automatic dm_driver(input int n);
    int          idx;
    logic        got, early, we;
    logic [31:0] addr;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) tick();
      idx   = int'($urandom_range(0, 15));
      addr  = 32'(idx) << 2;
      we    = 1'($urandom_range(0, 1));
      early = ($urandom_range(0, 3) == 0);
      issue_dm(we, addr, $urandom, 1);
      got = 1'b0;
      for (int w = 0; w < 2 * PER && !got; w++) begin
        @(negedge clk_i);
        if (dm_ack_o) got = 1'b1;
        else if (early && dm_req_i && mem_en_o && mem_addr_o == addr && mem_we_o == we) begin
          @(posedge clk_i);
          #1 dm_req_i = 1'b0;
        end
      end
      check("dm_wait_bound", 64'(got), 64'd1);
      tick();
      dm_req_i = 1'b0;
    end
  endtask

  initial begin
    logic got;
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
    ref_mem[4] = 32'hDEAD_BEEF;
    #1 rst_i = 1'b1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h10;
    repeat (3) tick();

    // Single fetch straight out of reset.
    rst_i = 1'b0;
    issue_if(32'h10, 1);
    run_cycles(PER + 2, 1, 0);
    check("fetch_mem_en_cycles", en_v, span(1, LAT));
    check("fetch_ack_cycle", ia_v, span(LAT + 1, 1));
    check("fetch_stall_cycles", st_v, span(0, LAT + 1));
    check("fetch_data_held", 64'(if_data_o), 64'h0000_0000_DEAD_BEEF);

    // Contention after reset: DM first, then alternation while both stay asserted.
    do_reset();
    issue_if(32'h84, 2);
    issue_dm(1'b0, 32'h08, 32'h0000_1111, 2);
    run_cycles(4 * PER + 1, 2, 2);
    check("contend_dm_acks", da_v, span(LAT + 1, 1) | span(LAT + 1 + 2 * PER, 1));
    check("contend_if_acks", ia_v, span(LAT + 1 + PER, 1) | span(LAT + 1 + 3 * PER, 1));
    check("contend_mem_en", en_v, span(1, LAT) | span(1 + PER, LAT) | span(1 + 2 * PER, LAT) | span(1 + 3 * PER, LAT));

    // Write of 0x5 to 0x4, then read it back.
    issue_dm(1'b1, 32'h4, 32'h5, 1);
    run_cycles(PER + 1, 0, 1);
    check("write_we_cycles", we_v, span(1, LAT));
    check("write_ack_cycle", da_v, span(LAT + 1, 1));
    check("write_keeps_rdata", 64'(dm_rdata_o), 64'(seed_word(2)));
    issue_dm(1'b0, 32'h4, 32'h0, 1);
    run_cycles(PER + 1, 0, 1);
    check("readback_after_write", 64'(dm_rdata_o), 64'h5);

    // Reset in the second access cycle aborts the fetch.
    issue_if(32'hC0, 1);
    tick();
    tick();
    check("abort_en_before_reset", 64'(mem_en_o), 64'd1);
    #2 rst_i = 1'b1;
    if_req_i = 1'b0;
    if_q.delete();
    dm_q.delete();
    dm_last = 32'd0;
    #1 check("abort_async_clear", 64'(|{mem_en_o, busy_o, if_data_o, dm_rdata_o, stall_o}), 64'd0);
    tick();
    rst_i = 1'b0;
    run_cycles(2 * PER, 0, 0);
    check("abort_no_ack", ia_v | da_v, 64'd0);
    check("abort_no_access", en_v, 64'd0);
    issue_dm(1'b0, 32'h40, 32'h0, 1);
    run_cycles(PER + 1, 0, 1);
    check("post_abort_mem_en", en_v, span(1, LAT));
    check("post_abort_ack", da_v, span(LAT + 1, 1));

    // Request withdrawn after grant still completes.
    issue_if(32'hC4, 1);
    tick();
    tick();
    if_req_i = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 2 * PER && !got; w++) begin
      @(negedge clk_i);
      if (if_ack_o) got = 1'b1;
    end
    check("withdrawn_request_acked", 64'(got), 64'd1);
    tick();

    fork
      if_driver(40);
      dm_driver(40);
    join
    repeat (4) tick();
    check("if_queue_drained", 64'(if_q.size()), 64'd0);
    check("dm_queue_drained", 64'(dm_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LAT, default 3, memory access latency in cycles; legal range 1..15.
REQ-002 clk_i  input  1  clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 if_req_i  input  1  instruction-fetch read request; held high until if_ack_o.
REQ-005 if_addr_i  input  32  fetch byte address.
REQ-006 if_ack_o  output  1  one-cycle pulse marking fetch completion.
REQ-007 if_data_o  output  32  fetched word.
REQ-008 dm_req_i  input  1  data-memory request; held high until dm_ack_o.
REQ-009 dm_we_i  input  1  1 = write, 0 = read.
REQ-010 dm_addr_i  input  32  data byte address.
REQ-011 dm_wdata_i  input  32  write data.
REQ-012 dm_ack_o  output  1  one-cycle pulse marking data-access completion.
REQ-013 dm_rdata_o  output  32  read data.
REQ-014 mem_en_o  output  1  shared single-port memory enable.
REQ-015 mem_we_o  output  1  memory write enable.
REQ-016 mem_addr_o  output  32  memory address.
REQ-017 mem_wdata_o  output  32  memory write data.
REQ-018 mem_rdata_i  input  32  memory read data, valid in the last ACCESS cycle.
REQ-019 stall_o  output  1  pipeline freeze request.
REQ-020 busy_o  output  1  high when state is not IDLE.

Function
REQ-021 States: IDLE, ACCESS, RESP.
REQ-022 IDLE: neither request asserted -> stay in IDLE.
REQ-023 IDLE, exactly one request asserted -> grant that requester and move to ACCESS.
REQ-024 IDLE, both requests asserted -> grant the requester not recorded in last_owner; last_owner updates on every grant.
REQ-025 On grant, latch owner, address, we and wdata (wdata and we are 0 for IF); the memory outputs drive only latched values.
REQ-026 ACCESS lasts exactly LAT cycles: mem_en_o=1, mem_we_o = latched we; a 4-bit down-counter loads LAT-1 on grant and ACCESS exits when it reaches 0.
REQ-027 On the last ACCESS edge of a read, mem_rdata_i is captured into the owner's data register (if_data_o or dm_rdata_o).
REQ-028 RESP lasts one cycle: the owner's ack_o=1 and mem_en_o=0; next state is always IDLE.
REQ-029 Sustained throughput is one access per LAT+2 cycles.
REQ-030 if_data_o and dm_rdata_o hold their value until the next read by the same owner; a write leaves dm_rdata_o unchanged.
REQ-031 Deasserting a request after grant is ignored: the access completes and the ack still pulses.
REQ-032 A request still high in its own RESP cycle is not served again; it competes as a new request in the following IDLE cycle.
REQ-033 stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-034 When idle, mem_addr_o, mem_wdata_o and mem_we_o are 0.

Reset
REQ-035 rst_i high forces immediately: state IDLE, counter 0, last_owner = IF.
REQ-036 rst_i high forces immediately: all outputs 0, including if_data_o and dm_rdata_o.
REQ-037 Reset during ACCESS or RESP aborts the access: no ack is issued after reset is released, and a write already issued is not repeated.
REQ-038 After reset is released, the first contention between both requesters grants DM.

Verification (LAT=3, cycle 0 = first edge after reset release)
REQ-039 Hold rst_i high -> all outputs 0 and busy_o=0; assert rst_i mid-cycle -> outputs clear before the next edge.
REQ-040 if_req_i=1 with if_addr_i=0x10 sampled at cycle 0, mem_rdata_i=0xDEADBEEF -> mem_en_o high in cycles 1-3, if_ack_o in cycle 4, if_data_o=0xDEADBEEF, stall_o high in cycles 0-3.
REQ-041 Both requests at cycle 0 -> DM served (ACCESS 1-3, dm_ack_o in 4); IF then granted at the cycle-5 IDLE (ACCESS 6-8, if_ack_o in 9).
REQ-042 dm_req_i held high continuously with if_req_i pending -> grants alternate DM, IF, DM; neither requester waits more than 2*(LAT+2) cycles.
REQ-043 DM write of 0x5 to address 0x4 -> mem_we_o=1, mem_addr_o=0x4, mem_wdata_o=0x5 in cycles 1-3; dm_rdata_o unchanged.
REQ-044 rst_i pulsed in the 2nd ACCESS cycle -> mem_en_o drops in that cycle, no ack after release, next request is served normally with full LAT.
